// File: rtl/notif_endp_ctrl.sv
// Interrupt IN endpoint that reports UART serial-state changes to the host as
// 10-byte SERIAL_STATE notifications, split into max-packet-size IN packets.
module notif_endp_ctrl #(
  parameter int          INT_MAXPACKETSIZE = 8,
  parameter logic [3:0]  ENDP_INT          = 4'd2,
  parameter logic [7:0]  COMM_IF           = 8'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] endp_i,
  input  logic       in_req_i,
  input  logic       in_ready_i,
  input  logic       in_ack_i,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       configured_i,
  input  logic [6:0] serial_state_i,
  output logic       busy_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PEND     = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;
  localparam logic [1:0] WAIT_ACK = 2'd3;

  localparam logic [4:0] L_MPS     = 5'(INT_MAXPACKETSIZE);
  localparam logic [4:0] L_MSG_LEN = 5'd10;

  logic [1:0] r_state;
  logic [6:0] r_last;
  logic [6:0] r_snap;
  logic [4:0] r_offset;
  logic [4:0] r_bc;

  logic [1:0] w_state_n;
  logic [6:0] w_last_n;
  logic [6:0] w_snap_n;
  logic [4:0] w_off_n;
  logic [4:0] w_bc_n;
  logic [4:0] w_remain;
  logic [4:0] w_pkt_len;
  logic [4:0] w_bc_inc;
  logic [4:0] w_off_adv;
  logic       w_ep;

  // Notification byte at message index idx; bytes not listed are zero.
  function automatic logic [7:0] f_msg(input logic [4:0] idx, input logic [6:0] snap);
    case (idx)
      5'd0:    f_msg = 8'hA1;
      5'd1:    f_msg = 8'h20;
      5'd4:    f_msg = COMM_IF;
      5'd6:    f_msg = 8'h02;
      5'd8:    f_msg = {1'b0, snap};
      default: f_msg = 8'h00;
    endcase
  endfunction

  assign w_ep      = (endp_i == ENDP_INT);
  assign w_remain  = L_MSG_LEN - r_offset;
  assign w_pkt_len = (L_MPS < w_remain) ? L_MPS : w_remain;
  assign w_bc_inc  = r_bc + 5'd1;
  assign w_off_adv = r_offset + w_pkt_len;

  // Next-state logic; the packet start index is the current message offset.
  always_comb begin
    w_state_n = r_state;
    w_last_n  = r_last;
    w_snap_n  = r_snap;
    w_off_n   = r_offset;
    w_bc_n    = r_bc;
    if (!configured_i) begin
      w_state_n = IDLE;
      w_last_n  = 7'd0;
      w_off_n   = 5'd0;
      w_bc_n    = 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (serial_state_i != r_last) begin
            w_snap_n  = serial_state_i;
            w_off_n   = 5'd0;
            w_bc_n    = 5'd0;
            w_state_n = PEND;
          end else begin
            w_state_n = IDLE;
          end
        end
        PEND: begin
          if (w_ep && in_req_i) begin
            w_bc_n    = 5'd0;
            w_state_n = SEND;
          end else begin
            w_state_n = PEND;
          end
        end
        SEND: begin
          if (w_ep && in_ready_i) begin
            w_bc_n = w_bc_inc;
            if ((w_bc_inc == w_pkt_len) || ((r_offset + w_bc_inc) == L_MSG_LEN)) begin
              w_state_n = WAIT_ACK;
            end else begin
              w_state_n = SEND;
            end
          end else begin
            w_state_n = SEND;
          end
        end
        WAIT_ACK: begin
          // ACK wins over a simultaneous IN token.
          if (w_ep && in_ack_i) begin
            w_off_n = w_off_adv;
            w_bc_n  = 5'd0;
            if (w_off_adv < L_MSG_LEN) begin
              w_state_n = PEND;
            end else begin
              w_last_n  = r_snap;
              w_state_n = IDLE;
            end
          end else if (w_ep && in_req_i) begin
            w_bc_n    = 5'd0;
            w_state_n = SEND;
          end else begin
            w_state_n = WAIT_ACK;
          end
        end
        default: begin
          w_state_n = IDLE;
        end
      endcase
    end
  end

  // State registers; outputs are registered from the next-state values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_last     <= 7'd0;
      r_snap     <= 7'd0;
      r_offset   <= 5'd0;
      r_bc       <= 5'd0;
      in_valid_o <= 1'b0;
      in_data_o  <= 8'h00;
      busy_o     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_last     <= w_last_n;
      r_snap     <= w_snap_n;
      r_offset   <= w_off_n;
      r_bc       <= w_bc_n;
      in_valid_o <= (w_state_n == SEND);
      in_data_o  <= (w_state_n == SEND) ? f_msg(w_off_n + w_bc_n, w_snap_n) : 8'h00;
      busy_o     <= (w_state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_notif_endp_ctrl.sv
// Directed bench for notif_endp_ctrl: full messages, NAK, replay, wrong
// endpoint, ACK/IN collision, state change in flight, unconfigure and reset.
module tb_notif_endp_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] endp_i;
  logic       in_req_i;
  logic       in_ready_i;
  logic       in_ack_i;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       configured_i;
  logic [6:0] serial_state_i;
  logic       busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] m [10];

  notif_endp_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .endp_i         (endp_i),
    .in_req_i       (in_req_i),
    .in_ready_i     (in_ready_i),
    .in_ack_i       (in_ack_i),
    .in_data_o      (in_data_o),
    .in_valid_o     (in_valid_o),
    .configured_i   (configured_i),
    .serial_state_i (serial_state_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_msg(input logic [6:0] s);
    m[0] = 8'hA1; m[1] = 8'h20; m[2] = 8'h00; m[3] = 8'h00; m[4] = 8'h00;
    m[5] = 8'h00; m[6] = 8'h02; m[7] = 8'h00; m[8] = {1'b0, s}; m[9] = 8'h00;
  endtask

  // IN token, then consume len bytes with in_ready held high.
  task automatic send_pkt(input string tag, input int start, input int len,
                          input int chg_at, input logic [6:0] chg_val);
    in_req_i = 1'b1;
    tick();
    in_req_i   = 1'b0;
    in_ready_i = 1'b1;
    for (int i = 0; i < len; i++) begin
      chk({tag, " valid"}, {7'd0, in_valid_o}, 8'd1);
      chk({tag, " data"}, in_data_o, m[start + i]);
      if (i == chg_at) serial_state_i = chg_val;
      tick();
    end
    in_ready_i = 1'b0;
    chk({tag, " eop"}, {7'd0, in_valid_o}, 8'd0);
  endtask

  task automatic ack();
    in_ack_i = 1'b1;
    tick();
    in_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; endp_i = 4'd2; in_req_i = 1'b0; in_ready_i = 1'b0; in_ack_i = 1'b0;
    configured_i = 1'b0; serial_state_i = 7'h00;
    tick(); tick();
    chk("reset valid", {7'd0, in_valid_o}, 8'd0);
    chk("reset data", in_data_o, 8'h00);
    chk("reset busy", {7'd0, busy_o}, 8'd0);
    rst_i = 1'b0; configured_i = 1'b1;
    tick();
    chk("idle busy", {7'd0, busy_o}, 8'd0);

    // IN token with nothing to report is a NAK
    in_req_i = 1'b1; tick(); in_req_i = 1'b0;
    chk("nak valid", {7'd0, in_valid_o}, 8'd0);
    chk("nak busy", {7'd0, busy_o}, 8'd0);
    tick();
    chk("nak valid2", {7'd0, in_valid_o}, 8'd0);

    serial_state_i = 7'h03; build_msg(7'h03);
    tick();
    chk("pend busy", {7'd0, busy_o}, 8'd1);
    chk("pend valid", {7'd0, in_valid_o}, 8'd0);
    endp_i = 4'd1; in_req_i = 1'b1; tick(); in_req_i = 1'b0; endp_i = 4'd2;
    chk("wrong ep valid", {7'd0, in_valid_o}, 8'd0);
    chk("wrong ep busy", {7'd0, busy_o}, 8'd1);
    tick();
    chk("wrong ep valid2", {7'd0, in_valid_o}, 8'd0);

    send_pkt("m1p1", 0, 8, -1, 7'h00);
    send_pkt("m1replay", 0, 8, -1, 7'h00);
    ack();
    chk("m1 mid busy", {7'd0, busy_o}, 8'd1);
    send_pkt("m1p2", 8, 2, -1, 7'h00);
    ack();
    chk("m1 done busy", {7'd0, busy_o}, 8'd0);
    tick();
    chk("m1 stays idle", {7'd0, busy_o}, 8'd0);

    // serial state changes while the 06 message is in flight
    serial_state_i = 7'h06; build_msg(7'h06);
    tick();
    chk("m2 busy", {7'd0, busy_o}, 8'd1);
    send_pkt("m2p1", 0, 8, 3, 7'h05);
    in_ack_i = 1'b1; in_req_i = 1'b1; tick(); in_ack_i = 1'b0; in_req_i = 1'b0;
    chk("ack+req valid", {7'd0, in_valid_o}, 8'd0);
    chk("ack+req busy", {7'd0, busy_o}, 8'd1);
    send_pkt("m2p2", 8, 2, -1, 7'h00);
    ack();
    chk("m2 done busy", {7'd0, busy_o}, 8'd0);
    tick();
    chk("m3 busy", {7'd0, busy_o}, 8'd1);
    build_msg(7'h05);
    send_pkt("m3p1", 0, 8, -1, 7'h00);
    ack();
    send_pkt("m3p2", 8, 2, -1, 7'h00);
    ack();
    chk("m3 done busy", {7'd0, busy_o}, 8'd0);

    // unconfigure mid-packet
    serial_state_i = 7'h03; build_msg(7'h03);
    tick();
    in_req_i = 1'b1; tick(); in_req_i = 1'b0; in_ready_i = 1'b1;
    tick(); tick();
    chk("uncfg pre data", in_data_o, m[2]);
    configured_i = 1'b0;
    tick();
    in_ready_i = 1'b0;
    chk("uncfg valid", {7'd0, in_valid_o}, 8'd0);
    chk("uncfg busy", {7'd0, busy_o}, 8'd0);
    chk("uncfg data", in_data_o, 8'h00);
    serial_state_i = 7'h00; configured_i = 1'b1;
    tick(); tick();
    chk("last cleared", {7'd0, busy_o}, 8'd0);
    serial_state_i = 7'h03;
    tick();
    chk("m4 busy", {7'd0, busy_o}, 8'd1);
    send_pkt("m4p1", 0, 8, -1, 7'h00);
    ack();

    // reset during the tail packet
    in_req_i = 1'b1; tick(); in_req_i = 1'b0;
    chk("m4p2 valid", {7'd0, in_valid_o}, 8'd1);
    chk("m4p2 data", in_data_o, m[8]);
    rst_i = 1'b1;
    #1;
    chk("rst valid", {7'd0, in_valid_o}, 8'd0);
    chk("rst busy", {7'd0, busy_o}, 8'd0);
    chk("rst data", in_data_o, 8'h00);
    tick();
    rst_i = 1'b0;
    tick();
    chk("m5 busy", {7'd0, busy_o}, 8'd1);
    send_pkt("m5p1", 0, 8, -1, 7'h00);
    ack();
    send_pkt("m5p2", 8, 2, -1, 7'h00);
    ack();
    chk("m5 done busy", {7'd0, busy_o}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
